// File: rtl/sap2_pkg.sv
// sap2_pkg: shared definitions for the SAP-2 core.
//   - OP_*      : 4-bit opcodes held in the top nibble of the instruction word
//   - state_e   : micro-sequencer states
//   - DBG_*     : dbg_sel encodings for the registered debug view
package sap2_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_STA = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JC  = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    StProg,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StHalt
  } state_e;

  localparam logic [1:0] DBG_FLAGS = 2'd0;
  localparam logic [1:0] DBG_PC    = 2'd1;
  localparam logic [1:0] DBG_MEM   = 2'd2;
  localparam logic [1:0] DBG_IR    = 2'd3;

endpackage

// File: rtl/sap2_ram.sv
// sap2_ram: single-port program/data memory, 2**ADDR_W x DATA_W.
//   sysclk : write clock
//   we     : synchronous write enable
//   adr    : shared read/write address
//   wdata  : write data
//   rdata  : asynchronous read data at adr
// Contents are not reset.
module sap2_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              sysclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge sysclk) begin
    if (we) mem[adr] <= wdata;
  end

  assign rdata = mem[adr];

endmodule

// File: rtl/sap2_core.sv
// sap2_core: single-bus accumulator machine with a micro-sequenced fetch/execute.
//   sysclk, fp_clear       : clock, async active-high reset
//   clken                  : advance one micro-step per enabled edge
//   fp_prog, fp_write,
//   fp_adr, fp_data        : front-panel program mode and memory write port
//   o_out, out_strobe      : output register and its load pulse
//   halt                   : core is halted
//   dbg_sel, dbg_out       : registered debug view (flags / PC / mem / IR)
module sap2_core
  import sap2_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              sysclk,
  input  logic              fp_clear,
  input  logic              clken,
  input  logic              fp_prog,
  input  logic              fp_write,
  input  logic [ADDR_W-1:0] fp_adr,
  input  logic [DATA_W-1:0] fp_data,
  output logic [DATA_W-1:0] o_out,
  output logic              out_strobe,
  output logic              halt,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_out
);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, o_q, o_d, dbg_q, dbg_d;
  logic c_q, c_d, z_q, z_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;

  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign diff    = a_q - b_q;
  assign ram_adr = fp_prog ? fp_adr : mar_q;

  sap2_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .sysclk(sysclk),
    .we    (ram_we),
    .adr   (ram_adr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mar_d      = mar_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    o_d        = o_q;
    c_d        = c_q;
    z_d        = z_q;
    ram_we     = 1'b0;
    ram_wdata  = a_q;
    out_strobe = 1'b0;

    if (fp_prog) begin
      // Front panel owns the machine; PC is parked at 0 for a clean restart.
      state_d   = StProg;
      pc_d      = '0;
      ram_we    = fp_write;
      ram_wdata = fp_data;
    end else if (state_q == StProg) begin
      state_d = StT1;
    end else if (clken) begin
      unique case (state_q)
        StT1: begin
          mar_d   = pc_q;
          state_d = StT2;
        end
        StT2: begin
          ir_d    = ram_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StT3;
        end
        StT3: begin
          state_d = StT1;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar_d   = operand;
              state_d = StT4;
            end
            OP_LDI: a_d = DATA_W'(operand);
            OP_JMP: pc_d = operand;
            OP_JC:  if (c_q) pc_d = operand;
            OP_JZ:  if (z_q) pc_d = operand;
            OP_OUT: begin
              o_d        = a_q;
              out_strobe = 1'b1;
            end
            OP_HLT: state_d = StHalt;
            default: ;
          endcase
        end
        StT4: begin
          state_d = StT1;
          case (opcode)
            OP_LDA: a_d = ram_rdata;
            OP_ADD, OP_SUB: begin
              b_d     = ram_rdata;
              state_d = StT5;
            end
            OP_STA: ram_we = 1'b1;
            default: ;
          endcase
        end
        StT5: begin
          state_d = StT1;
          if (opcode == OP_SUB) begin
            a_d = diff;
            c_d = (a_q >= b_q);  // no-borrow
            z_d = (diff == '0);
          end else begin
            a_d = sum[DATA_W-1:0];
            c_d = sum[DATA_W];
            z_d = (sum[DATA_W-1:0] == '0);
          end
        end
        StHalt: state_d = StHalt;
        StProg: state_d = StT1;
        default: state_d = StT1;
      endcase
    end
  end

  always_comb begin
    dbg_d = '0;
    unique case (dbg_sel)
      DBG_FLAGS: dbg_d = DATA_W'({c_q, z_q});
      DBG_PC:    dbg_d = DATA_W'(pc_q);
      DBG_MEM:   dbg_d = ram_rdata;
      DBG_IR:    dbg_d = ir_q;
      default:   dbg_d = '0;
    endcase
  end

  always_ff @(posedge sysclk or posedge fp_clear) begin
    if (fp_clear) begin
      state_q <= StT1;
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      o_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      o_q     <= o_d;
      c_q     <= c_d;
      z_q     <= z_d;
      dbg_q   <= dbg_d;
    end
  end

  assign o_out   = o_q;
  assign halt    = (state_q == StHalt);
  assign dbg_out = dbg_q;

endmodule
